// File: rtl/usb4_clk_pkg.sv
// Shared definitions for the USB4 clock-enable / reset-sequencing generator.
package usb4_clk_pkg;

    // Generation encoding on gen_sel_i / gen_active_o
    localparam int GEN2 = 0;
    localparam int GEN3 = 1;
    localparam int GEN4 = 2;

    // System-reset sequencer states
    typedef enum logic {
        RST_HOLD = 1'b0,
        RST_RUN  = 1'b1
    } rst_state_e;

    // Channel 0 is sideband; each generation owns a lane/FSM channel pair after it.
    function automatic int lane_ch(input int g);
        return 1 + 2 * g;
    endfunction

    function automatic int fsm_ch(input int g);
        return 2 + 2 * g;
    endfunction

endpackage

// File: rtl/usb4_nco_ch.sv
// One phase-accumulator channel: increment register, accumulator and a
// registered single-cycle carry tick. A write reloads the increment, clears
// the accumulator and suppresses the tick on that edge.
module usb4_nco_ch #(
    parameter int               ACC_W   = 32,
    parameter logic [ACC_W-1:0] INC_RST = '0
) (
    input  logic             local_clk,
    input  logic             rst,
    input  logic             wr_i,
    input  logic [ACC_W-1:0] inc_i,
    output logic             tick_o,
    output logic             carry_nxt_o
);

    logic [ACC_W-1:0] acc_q, acc_d;
    logic [ACC_W-1:0] inc_q, inc_d;
    logic             tick_q, tick_d;
    logic [ACC_W:0]   sum;

    // Next-state: accumulate with carry-out, or reload on a config write
    always_comb begin
        sum    = {1'b0, acc_q} + {1'b0, inc_q};
        acc_d  = sum[ACC_W-1:0];
        inc_d  = inc_q;
        tick_d = sum[ACC_W];
        if (wr_i) begin
            inc_d  = inc_i;
            acc_d  = '0;
            tick_d = 1'b0;
        end
    end

    // Channel state registers
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            acc_q  <= '0;
            inc_q  <= INC_RST;
            tick_q <= 1'b0;
        end else begin
            acc_q  <= acc_d;
            inc_q  <= inc_d;
            tick_q <= tick_d;
        end
    end

    assign tick_o      = tick_q;
    // Value tick_o takes on the coming edge; lets the top act on the wrap edge itself
    assign carry_nxt_o = tick_d;

endmodule

// File: rtl/usb4_clk_enable_gen.sv
// Clock-enable and reset-sequencing generator: NUM_CH NCO channels, a
// glitch-free lane/FSM generation mux switched on sideband ticks, and a
// sideband-tick-counted system reset sequencer.
module usb4_clk_enable_gen
    import usb4_clk_pkg::*;
#(
    parameter  int NUM_GEN        = 3,
    parameter  int ACC_W          = 32,
    parameter  int SB_INC_DEF     = 13422,
    parameter  int RST_HOLD_TICKS = 3,
    localparam int NUM_CH         = 1 + 2 * NUM_GEN,
    localparam int CH_W           = (NUM_CH > 1) ? $clog2(NUM_CH) : 1,
    localparam int GEN_W          = (NUM_GEN > 1) ? $clog2(NUM_GEN) : 1
) (
    input  logic              local_clk,
    input  logic              rst,
    input  logic              cfg_wr_i,
    input  logic [CH_W-1:0]   cfg_ch_i,
    input  logic [ACC_W-1:0]  cfg_inc_i,
    input  logic [GEN_W-1:0]  gen_sel_i,
    input  logic              sw_rst_req_i,
    output logic [NUM_CH-1:0] tick_o,
    output logic              sb_tick_o,
    output logic              lane_tick_o,
    output logic              fsm_tick_o,
    output logic [GEN_W-1:0]  gen_active_o,
    output logic              sys_rst_n_o
);

    localparam int HCNT_W = (RST_HOLD_TICKS > 0) ? $clog2(RST_HOLD_TICKS + 1) : 1;

    logic [NUM_CH-1:0]  wr_ch;
    logic [NUM_CH-1:0]  tick;
    logic [NUM_CH-1:0]  carry_nxt;
    logic [NUM_GEN-1:0] lane_vec;
    logic [NUM_GEN-1:0] fsm_vec;
    logic               sb_carry;

    // ------------------------------------------------------------------
    // NCO channels
    // ------------------------------------------------------------------
    for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
        localparam logic [ACC_W-1:0] RST_INC = (i == 0) ? ACC_W'(SB_INC_DEF) : '0;

        // Out-of-range cfg_ch_i matches no instance and is dropped here
        assign wr_ch[i] = cfg_wr_i && (int'(cfg_ch_i) == i);

        usb4_nco_ch #(
            .ACC_W   (ACC_W),
            .INC_RST (RST_INC)
        ) u_ch (
            .local_clk   (local_clk),
            .rst         (rst),
            .wr_i        (wr_ch[i]),
            .inc_i       (cfg_inc_i),
            .tick_o      (tick[i]),
            .carry_nxt_o (carry_nxt[i])
        );
    end

    assign sb_carry = carry_nxt[0];

    for (genvar g = 0; g < NUM_GEN; g++) begin : g_pair
        assign lane_vec[g] = tick[lane_ch(g)];
        assign fsm_vec[g]  = tick[fsm_ch(g)];
    end

    // ------------------------------------------------------------------
    // Generation select
    // ------------------------------------------------------------------
    logic [GEN_W-1:0] gen_active_q, gen_active_d;
    logic [GEN_W-1:0] gen_req_q, gen_req_d;
    logic             lane_q, lane_d;
    logic             fsm_q, fsm_d;
    logic             gen_ok;
    logic             gen_switch;

    // Latest in-range request is remembered until a sideband wrap applies it;
    // the switch edge forces both enables low so no partial tick escapes.
    always_comb begin
        gen_ok       = int'(gen_sel_i) < NUM_GEN;
        gen_req_d    = gen_ok ? gen_sel_i : gen_req_q;
        gen_switch   = sb_carry && (gen_req_d != gen_active_q);
        gen_active_d = gen_switch ? gen_req_d : gen_active_q;
        lane_d       = gen_switch ? 1'b0 : lane_vec[gen_active_q];
        fsm_d        = gen_switch ? 1'b0 : fsm_vec[gen_active_q];
    end

    // Generation mux registers
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            gen_active_q <= '0;
            gen_req_q    <= '0;
            lane_q       <= 1'b0;
            fsm_q        <= 1'b0;
        end else begin
            gen_active_q <= gen_active_d;
            gen_req_q    <= gen_req_d;
            lane_q       <= lane_d;
            fsm_q        <= fsm_d;
        end
    end

    // ------------------------------------------------------------------
    // System reset sequencer
    // ------------------------------------------------------------------
    rst_state_e        state_q, state_d;
    logic [HCNT_W-1:0] hcnt_q, hcnt_d;
    logic              rstn_q, rstn_d;
    logic              hold_done;

    // Next-state: count sideband wraps in HOLD; a software request always
    // restarts the hold (any coincident wrap is dropped)
    always_comb begin
        state_d   = state_q;
        hcnt_d    = hcnt_q;
        hold_done = (RST_HOLD_TICKS == 0) ||
                    (sb_carry && (int'(hcnt_q) + 1 >= RST_HOLD_TICKS));
        case (state_q)
            RST_HOLD: begin
                if (sw_rst_req_i) begin
                    hcnt_d = '0;
                end else if (hold_done) begin
                    state_d = RST_RUN;
                    hcnt_d  = '0;
                end else if (sb_carry) begin
                    hcnt_d = hcnt_q + HCNT_W'(1);
                end
            end
            RST_RUN: begin
                if (sw_rst_req_i) begin
                    state_d = RST_HOLD;
                    hcnt_d  = '0;
                end
            end
            default: begin
                state_d = RST_HOLD;
                hcnt_d  = '0;
            end
        endcase
        rstn_d = (state_d == RST_RUN);
    end

    // Sequencer state registers
    always_ff @(posedge local_clk or negedge rst) begin
        if (!rst) begin
            state_q <= RST_HOLD;
            hcnt_q  <= '0;
            rstn_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            hcnt_q  <= hcnt_d;
            rstn_q  <= rstn_d;
        end
    end

    assign tick_o       = tick;
    assign sb_tick_o    = tick[0];
    assign lane_tick_o  = lane_q;
    assign fsm_tick_o   = fsm_q;
    assign gen_active_o = gen_active_q;
    assign sys_rst_n_o  = rstn_q;

endmodule
